rgbw_spi_byte_receiver: RTL and testbench
=========================================

Name: rgbw_spi_byte_receiver

Overview:
SPI mode-0 slave front end for the RGBW controller. Oversamples the external SCK/MOSI/CS_n pins on the system clock, assembles bytes MSB-first and presents each completed byte with a stretched `rdy` level. `rdy` is sized so the downstream data dispenser, which samples at the half-rate enable, always sees a clean 0→1 edge. The block also shifts a status byte out on MISO.

Parameters:
RDY_HOLD, 8, clk cycles `rdy` stays high per byte (min 4 so a half-rate sampler catches it).
SYNC_STAGES, 2, synchroniser flops on each SPI input (2 or 3).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
spi_sck  input  1  SPI clock pin, idle low (mode 0)
spi_mosi  input  1  SPI data in
spi_cs_n  input  1  SPI chip select, active low
tx_byte  input  8  status byte to send; sampled at frame start and at each byte boundary
rx_byte  output  8  last completed received byte
rdy  output  1  high for RDY_HOLD clks after each completed byte
overrun  output  1  sticky: byte completed while rdy still high
frame_err  output  1  sticky: CS_n deasserted with partial byte
miso  output  1  SPI data out
miso_oe  output  1  MISO drive enable (= CS active, synchronised)

Behaviour:
- Reset (async assert, sync release): rx_byte=0x00, rdy=0, overrun=0, frame_err=0, miso=0, miso_oe=0. Bit counter=0. Shift registers=0. Synchroniser flops=idle (sck 0, cs_n 1, mosi 0). RDY timer=0.
- Inputs pass SYNC_STAGES flops, then one edge-detect flop. Pin edge → internal event latency is SYNC_STAGES+1 clk (3 at default).
- SCK frequency constraint: f_sck ≤ f_clk/8. No behaviour is guaranteed above this.
- FSM states: IDLE, ACTIVE.
  - IDLE: miso_oe=0. CS_n falling → ACTIVE. Same cycle: bit_cnt=0, tx shift ← tx_byte, miso ← tx_byte[7].
  - ACTIVE:
    - SCK rising: rx_shift ← {rx_shift[6:0], mosi_sync}; bit_cnt++.
    - SCK falling: tx shift left 1; miso ← next bit.
    - Bit 8 rising edge: rx_byte ← assembled byte (same cycle); bit_cnt ← 0; tx shift reloaded from tx_byte at the following falling edge; RDY timer ← RDY_HOLD.
    - CS_n rising → IDLE. If bit_cnt≠0: frame_err←1, partial byte discarded, rx_byte unchanged, no rdy.
- rdy = (RDY timer ≠ 0). Timer decrements every clk. rdy rises in the same cycle rx_byte updates. rx_byte is stable for at least RDY_HOLD clks thereafter.
- A byte completing while the timer is non-zero: overrun←1, rx_byte updated, timer reloaded. No new rising edge is generated (known data loss, flagged).
- SCK and CS_n events in the same clk: the CS_n event wins and the SCK edge is ignored.
- overrun and frame_err clear only on reset.
- Gaps between frames are unlimited. Back-to-back bytes within a frame need no gap. bit_cnt wraps 7→0 per byte.
- Reset mid-frame: all state is lost. After release, an active CS_n is ignored until it is seen high then low again (IDLE requires a CS_n falling edge).

Test Plan:
1. Reset with CS_n high, then one frame sending 0x55 → rx_byte=0x55, rdy high exactly 8 clks starting SYNC_STAGES+1 clks after the 8th SCK rise. overrun=0, frame_err=0.
2. Eight-byte frame 0x55,0x10,0x03,0xFF,0x80,0x00,0x7F,0x02 at f_clk/8 → 8 distinct rdy pulses, each low ≥4 clks between. rx_byte matches each byte in order.
3. tx_byte=0xA5 before CS_n fall, then 8 clocks → MISO sampled on SCK rising reads 0xA5. miso_oe low outside CS.
4. CS_n raised after 5 bits of 0xFF → frame_err=1, no rdy pulse, rx_byte holds its previous value. Next full frame 0x33 → rx_byte=0x33, frame_err stays 1.
5. RDY_HOLD=200 with bytes 0x11,0x22 back-to-back at f_clk/8 → overrun=1, rx_byte=0x22, only one rdy rising edge.
6. Reset asserted mid-byte → outputs 0 immediately (async). Release with CS_n still low and 8 SCKs → no rdy. CS_n high→low then 0x77 → rx_byte=0x77.

Source files
------------

// File: rtl/rgbw_spi_byte_receiver_if.sv
// SPI pin and byte-side bundle for the RGBW SPI byte receiver.
// The master side drives the SPI pins and the status byte. The slave side
// returns the received byte, its ready strobe, the error flags and MISO.
interface rgbw_spi_byte_receiver_if;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic [7:0] tx_byte;
  logic [7:0] rx_byte;
  logic       rdy;
  logic       overrun;
  logic       frame_err;
  logic       miso;
  logic       miso_oe;

  modport master (
    output spi_sck, spi_mosi, spi_cs_n, tx_byte,
    input  rx_byte, rdy, overrun, frame_err, miso, miso_oe
  );

  modport slave (
    input  spi_sck, spi_mosi, spi_cs_n, tx_byte,
    output rx_byte, rdy, overrun, frame_err, miso, miso_oe
  );
endinterface

// File: rtl/rgbw_spi_byte_receiver.sv
// SPI mode-0 slave front end for the RGBW controller.
// SCK, MOSI and CS_n are oversampled on clk. Bytes are assembled MSB-first
// and each one is presented on rx_byte together with a stretched rdy level,
// so that a half-rate sampler downstream always sees a clean rising edge.
// A status byte is shifted out on MISO. It is reloaded at every byte boundary.
module rgbw_spi_byte_receiver #(
  parameter int RDY_HOLD    = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic                     clk,
  input logic                     reset,
  rgbw_spi_byte_receiver_if.slave bus
);

  localparam int TW = $clog2(RDY_HOLD + 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Internal reset: asserts asynchronously and releases on a clk edge
  logic [1:0]             rst_sync_r;
  logic                   rst_n_s;

  // Pin synchronisers, edge-detect flops and the power-up arming logic
  logic [SYNC_STAGES-1:0] sck_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic [SYNC_STAGES-1:0] fill_r;
  logic                   sck_d_r;
  logic                   cs_d_r;
  logic                   armed_r;
  logic                   sck_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   chain_valid_s;
  logic                   sck_rise_s;
  logic                   sck_fall_s;
  logic                   cs_rise_s;
  logic                   cs_fall_s;

  // Frame control and datapath
  state_e                 state_r;
  state_e                 state_next_s;
  logic                   start_s;
  logic                   stop_s;
  logic                   shift_in_s;
  logic                   shift_out_s;
  logic                   byte_done_s;
  logic [2:0]             bit_cnt_r;
  logic [6:0]             rx_shift_r;
  logic [6:0]             tx_shift_r;
  logic                   reload_r;
  logic [7:0]             rx_byte_r;
  logic [TW-1:0]          timer_r;
  logic [TW-1:0]          timer_next_s;
  logic                   rdy_r;
  logic                   overrun_r;
  logic                   frame_err_r;
  logic                   miso_r;
  logic                   miso_oe_r;

  // Two-flop reset release synchroniser
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // Synchronise the SPI pins and keep one extra flop per clock/select for edge detection
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      sck_sync_r  <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      fill_r      <= {SYNC_STAGES{1'b0}};
      sck_d_r     <= 1'b0;
      cs_d_r      <= 1'b1;
      armed_r     <= 1'b0;
    end else begin
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], bus.spi_sck};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], bus.spi_cs_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], bus.spi_mosi};
      fill_r      <= {fill_r[SYNC_STAGES-2:0], 1'b1};
      sck_d_r     <= sck_s;
      cs_d_r      <= cs_s;
      // Only a CS_n high that was really sampled from the pin (not the
      // reset value) allows the next falling edge to open a frame.
      if (chain_valid_s && cs_s) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  assign sck_s         = sck_sync_r[SYNC_STAGES-1];
  assign cs_s          = cs_sync_r[SYNC_STAGES-1];
  assign mosi_s        = mosi_sync_r[SYNC_STAGES-1];
  assign chain_valid_s = fill_r[SYNC_STAGES-1];

  assign sck_rise_s = sck_s & ~sck_d_r;
  assign sck_fall_s = ~sck_s & sck_d_r;
  assign cs_fall_s  = armed_r & cs_d_r & ~cs_s;
  assign cs_rise_s  = cs_s & ~cs_d_r;

  // A CS_n event in the same clk as an SCK edge takes priority; the SCK edge is dropped
  assign start_s     = (state_r == ST_IDLE) & cs_fall_s;
  assign stop_s      = (state_r == ST_ACTIVE) & cs_rise_s;
  assign shift_in_s  = (state_r == ST_ACTIVE) & ~cs_rise_s & ~cs_fall_s & sck_rise_s;
  assign shift_out_s = (state_r == ST_ACTIVE) & ~cs_rise_s & ~cs_fall_s & sck_fall_s;
  assign byte_done_s = shift_in_s & (bit_cnt_r == 3'd7);

  // Frame state register
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Frame next-state: open on CS_n falling, close on CS_n rising
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_next_s = ST_ACTIVE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_ACTIVE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Ready timer: loads on each completed byte and counts down to zero
  always_comb begin
    timer_next_s = timer_r;
    if (byte_done_s) begin
      timer_next_s = TW'(RDY_HOLD);
    end else if (timer_r != {TW{1'b0}}) begin
      timer_next_s = timer_r - TW'(1);
    end else begin
      timer_next_s = timer_r;
    end
  end

  // Receive/transmit shifters, byte capture, sticky flags and registered outputs
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      bit_cnt_r   <= 3'd0;
      rx_shift_r  <= 7'h00;
      tx_shift_r  <= 7'h00;
      reload_r    <= 1'b0;
      rx_byte_r   <= 8'h00;
      timer_r     <= {TW{1'b0}};
      rdy_r       <= 1'b0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
      miso_r      <= 1'b0;
      miso_oe_r   <= 1'b0;
    end else begin
      timer_r   <= timer_next_s;
      rdy_r     <= (timer_next_s != {TW{1'b0}});
      miso_oe_r <= (state_next_s == ST_ACTIVE);
      if (start_s) begin
        bit_cnt_r  <= 3'd0;
        rx_shift_r <= 7'h00;
        tx_shift_r <= bus.tx_byte[6:0];
        miso_r     <= bus.tx_byte[7];
        reload_r   <= 1'b0;
      end else if (stop_s) begin
        // A partial byte is dropped and only flagged; rx_byte keeps its value
        if (bit_cnt_r != 3'd0) begin
          frame_err_r <= 1'b1;
        end
        bit_cnt_r  <= 3'd0;
        rx_shift_r <= 7'h00;
        miso_r     <= 1'b0;
        reload_r   <= 1'b0;
      end else if (shift_in_s) begin
        rx_shift_r <= {rx_shift_r[5:0], mosi_s};
        bit_cnt_r  <= bit_cnt_r + 3'd1;
        if (byte_done_s) begin
          rx_byte_r <= {rx_shift_r, mosi_s};
          reload_r  <= 1'b1;
          if (timer_r != {TW{1'b0}}) begin
            overrun_r <= 1'b1;
          end
        end
      end else if (shift_out_s) begin
        // The falling edge after a byte boundary starts the next status byte
        if (reload_r) begin
          tx_shift_r <= bus.tx_byte[6:0];
          miso_r     <= bus.tx_byte[7];
          reload_r   <= 1'b0;
        end else begin
          tx_shift_r <= {tx_shift_r[5:0], 1'b0};
          miso_r     <= tx_shift_r[6];
        end
      end
    end
  end

  assign bus.rx_byte   = rx_byte_r;
  assign bus.rdy       = rdy_r;
  assign bus.overrun   = overrun_r;
  assign bus.frame_err = frame_err_r;
  assign bus.miso      = miso_r;
  assign bus.miso_oe   = miso_oe_r;

endmodule

// File: tb/tb_rgbw_spi_byte_receiver.sv
// Self-checking bench for rgbw_spi_byte_receiver.
// Two instances share the SPI pins: one uses the default RDY_HOLD and one
// uses RDY_HOLD=200 to reach the overrun case. Expectations come from the
// byte lists that the bench sends, together with the pin-to-output timing
// rules of the design.
module tb_rgbw_spi_byte_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       cs_n = 1'b1;
  logic [7:0] tx = 8'h00;

  int checks = 0;
  int errors = 0;

  // Monitor state, written only by the monitor process
  int   rise_a = 0;
  int   rise_b = 0;
  int   low_run_a = 0;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;
  logic seen_high_a = 1'b0;
  int   gaps_a[$];

  // Reference model: last complete byte received by the default instance
  logic [7:0] exp_rx = 8'h00;

  rgbw_spi_byte_receiver_if if_a ();
  rgbw_spi_byte_receiver_if if_b ();

  assign if_a.spi_sck  = sck;
  assign if_a.spi_mosi = mosi;
  assign if_a.spi_cs_n = cs_n;
  assign if_a.tx_byte  = tx;
  assign if_b.spi_sck  = sck;
  assign if_b.spi_mosi = mosi;
  assign if_b.spi_cs_n = cs_n;
  assign if_b.tx_byte  = tx;

  rgbw_spi_byte_receiver #(.RDY_HOLD(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(rst_n), .bus(if_a)
  );

  rgbw_spi_byte_receiver #(.RDY_HOLD(200), .SYNC_STAGES(2)) dut_ov (
    .clk(clk), .reset(rst_n), .bus(if_b)
  );

  always #5 clk = ~clk;

  // Count rdy rising edges and record how long rdy was low before each one
  always @(negedge clk) begin
    if (if_a.rdy && !prev_a) begin
      rise_a = rise_a + 1;
      if (seen_high_a) gaps_a.push_back(low_run_a);
    end
    if (if_a.rdy) begin
      low_run_a   = 0;
      seen_high_a = 1'b1;
    end else begin
      low_run_a = low_run_a + 1;
    end
    if (if_b.rdy && !prev_b) rise_b = rise_b + 1;
    prev_a = if_a.rdy;
    prev_b = if_b.rdy;
  end

  // Watchdog so that the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Drive one bit: MOSI set up, SCK high for 4 clks (MISO sampled at the rise), then low for 4 clks
  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    m = if_a.miso;
    repeat (4) @(negedge clk);
    sck = 1'b0;
  endtask

  // Drive one byte MSB-first; tx_next is presented on the 8th rise for the reload
  task automatic spi_byte(input logic [7:0] d, input logic [7:0] tx_next, output logic [7:0] m);
    for (int i = 7; i >= 0; i--) begin
      mosi = d[i];
      repeat (4) @(negedge clk);
      sck = 1'b1;
      m[i] = if_a.miso;
      if (i == 0) tx = tx_next;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    #1;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sck   = 1'b0;
    mosi  = 1'b0;
    cs_n  = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    exp_rx = 8'h00;
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    obs = {if_a.rx_byte, if_a.rdy, if_a.overrun, if_a.frame_err, if_a.miso, if_a.miso_oe};
    checks++;
    if (obs !== 13'h0000) begin
      errors++;
      $display("FAIL reset_during got %h exp %h", obs, 13'h0000);
    end
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    obs = {if_b.rx_byte, if_b.rdy, if_b.overrun, if_b.frame_err, if_b.miso, if_b.miso_oe};
    checks++;
    if (obs !== 13'h0000) begin
      errors++;
      $display("FAIL reset_after got %h exp %h", obs, 13'h0000);
    end
  endtask

  task automatic test_single();
    logic m;
    logic exp_rdy;
    int   r0;
    logic [7:0] d;
    d = 8'h55;
    tx = 8'h00;
    cs_low();
    for (int i = 7; i >= 1; i--) spi_bit(d[i], m);
    mosi = d[0];
    repeat (4) @(negedge clk);
    r0 = rise_a;
    sck = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) sck = 1'b0;
      exp_rdy = (k >= 3 && k <= 10);
      checks++;
      if (if_a.rdy !== exp_rdy) begin
        errors++;
        $display("FAIL rdy_window clk=%0d got %b exp %b", k, if_a.rdy, exp_rdy);
      end
    end
    exp_rx = d;
    checks++;
    if (if_a.rx_byte !== exp_rx) begin
      errors++;
      $display("FAIL single_rx got %h exp %h", if_a.rx_byte, exp_rx);
    end
    checks++;
    if ({if_a.overrun, if_a.frame_err} !== 2'b00) begin
      errors++;
      $display("FAIL single_flags got %b exp 00", {if_a.overrun, if_a.frame_err});
    end
    checks++;
    if (rise_a - r0 != 1) begin
      errors++;
      $display("FAIL single_rises got %0d exp 1", rise_a - r0);
    end
    cs_high();
  endtask

  task automatic test_multi();
    logic [7:0] bytes [0:7];
    logic [7:0] m;
    int r0;
    int g0;
    bytes = '{8'h55, 8'h10, 8'h03, 8'hFF, 8'h80, 8'h00, 8'h7F, 8'h02};
    r0 = rise_a;
    g0 = gaps_a.size();
    cs_low();
    for (int j = 0; j < 8; j++) begin
      spi_byte(bytes[j], 8'h00, m);
      exp_rx = bytes[j];
      checks++;
      if (if_a.rx_byte !== exp_rx || if_a.rdy !== 1'b1 || rise_a - r0 != j + 1) begin
        errors++;
        $display("FAIL multi_byte%0d got rx=%h rdy=%b rises=%0d exp rx=%h rdy=1 rises=%0d",
                 j, if_a.rx_byte, if_a.rdy, rise_a - r0, exp_rx, j + 1);
      end
    end
    cs_high();
    checks++;
    if (gaps_a.size() - g0 != 8) begin
      errors++;
      $display("FAIL multi_gap_count got %0d exp 8", gaps_a.size() - g0);
    end
    for (int g = g0; g < gaps_a.size(); g++) begin
      checks++;
      if (gaps_a[g] < 4) begin
        errors++;
        $display("FAIL multi_gap%0d got %0d exp >=4", g - g0, gaps_a[g]);
      end
    end
  endtask

  task automatic test_miso();
    logic [7:0] m;
    logic [7:0] d;
    checks++;
    if (if_a.miso_oe !== 1'b0) begin
      errors++;
      $display("FAIL miso_oe_idle got %b exp 0", if_a.miso_oe);
    end
    tx = 8'hA5;
    cs_low();
    checks++;
    if (if_a.miso_oe !== 1'b1) begin
      errors++;
      $display("FAIL miso_oe_active got %b exp 1", if_a.miso_oe);
    end
    d = 8'($urandom);
    spi_byte(d, 8'h00, m);
    exp_rx = d;
    checks++;
    if (m !== 8'hA5) begin
      errors++;
      $display("FAIL miso_byte got %h exp %h", m, 8'hA5);
    end
    cs_high();
    checks++;
    if (if_a.miso_oe !== 1'b0) begin
      errors++;
      $display("FAIL miso_oe_after got %b exp 0", if_a.miso_oe);
    end
  endtask

  task automatic test_frame_err();
    logic m;
    logic [7:0] mb;
    int r0;
    checks++;
    if (if_a.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL ferr_before got %b exp 0", if_a.frame_err);
    end
    r0 = rise_a;
    cs_low();
    for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
    cs_high();
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (if_a.frame_err !== 1'b1 || rise_a != r0 || if_a.rx_byte !== exp_rx) begin
      errors++;
      $display("FAIL ferr_partial got ferr=%b rises=%0d rx=%h exp ferr=1 rises=0 rx=%h",
               if_a.frame_err, rise_a - r0, if_a.rx_byte, exp_rx);
    end
    cs_low();
    spi_byte(8'h33, 8'h00, mb);
    exp_rx = 8'h33;
    cs_high();
    checks++;
    if (if_a.rx_byte !== exp_rx || if_a.frame_err !== 1'b1) begin
      errors++;
      $display("FAIL ferr_next got rx=%h ferr=%b exp rx=%h ferr=1", if_a.rx_byte, if_a.frame_err, exp_rx);
    end
  endtask

  task automatic test_random();
    logic [7:0] rxv [0:3];
    logic [7:0] txv [0:4];
    logic [7:0] m;
    int len;
    int r0;
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 4);
      for (int j = 0; j < 5; j++) txv[j] = 8'($urandom);
      for (int j = 0; j < 4; j++) rxv[j] = 8'($urandom);
      tx = txv[0];
      r0 = rise_a;
      cs_low();
      for (int j = 0; j < len; j++) begin
        spi_byte(rxv[j], txv[j + 1], m);
        exp_rx = rxv[j];
        checks++;
        if (if_a.rx_byte !== exp_rx || m !== txv[j] || rise_a - r0 != j + 1) begin
          errors++;
          $display("FAIL rand_f%0d_b%0d got rx=%h miso=%h rises=%0d exp rx=%h miso=%h rises=%0d",
                   f, j, if_a.rx_byte, m, rise_a - r0, exp_rx, txv[j], j + 1);
        end
      end
      cs_high();
    end
    checks++;
    if (if_a.overrun !== 1'b0) begin
      errors++;
      $display("FAIL rand_overrun got %b exp 0", if_a.overrun);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] m;
    int ra;
    int rb;
    do_reset();
    ra = rise_a;
    rb = rise_b;
    cs_low();
    spi_byte(8'h11, 8'h00, m);
    spi_byte(8'h22, 8'h00, m);
    exp_rx = 8'h22;
    cs_high();
    checks++;
    if (if_b.rx_byte !== 8'h22 || if_b.overrun !== 1'b1 || rise_b - rb != 1) begin
      errors++;
      $display("FAIL overrun_hold200 got rx=%h ovr=%b rises=%0d exp rx=22 ovr=1 rises=1",
               if_b.rx_byte, if_b.overrun, rise_b - rb);
    end
    checks++;
    if (if_a.rx_byte !== exp_rx || if_a.overrun !== 1'b0 || rise_a - ra != 2) begin
      errors++;
      $display("FAIL overrun_hold8 got rx=%h ovr=%b rises=%0d exp rx=%h ovr=0 rises=2",
               if_a.rx_byte, if_a.overrun, rise_a - ra, exp_rx);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic m;
    logic [7:0] mb;
    logic [12:0] obs;
    int r0;
    cs_low();
    for (int i = 0; i < 3; i++) spi_bit(1'b1, m);
    checks++;
    if (if_a.miso_oe !== 1'b1 || if_a.rx_byte !== exp_rx) begin
      errors++;
      $display("FAIL midrst_pre got oe=%b rx=%h exp oe=1 rx=%h", if_a.miso_oe, if_a.rx_byte, exp_rx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    obs = {if_a.rx_byte, if_a.rdy, if_a.overrun, if_a.frame_err, if_a.miso, if_a.miso_oe};
    checks++;
    if (obs !== 13'h0000) begin
      errors++;
      $display("FAIL midrst_async got %h exp %h", obs, 13'h0000);
    end
    exp_rx = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    r0 = rise_a;
    spi_byte(8'hAB, 8'h00, mb);
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (rise_a != r0 || if_a.rx_byte !== 8'h00 || if_a.miso_oe !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ignored got rises=%0d rx=%h oe=%b exp rises=0 rx=00 oe=0",
               rise_a - r0, if_a.rx_byte, if_a.miso_oe);
    end
    cs_high();
    cs_low();
    spi_byte(8'h77, 8'h00, mb);
    exp_rx = 8'h77;
    checks++;
    if (if_a.rx_byte !== exp_rx || if_a.rdy !== 1'b1 || rise_a - r0 != 1) begin
      errors++;
      $display("FAIL midrst_rearm got rx=%h rdy=%b rises=%0d exp rx=%h rdy=1 rises=1",
               if_a.rx_byte, if_a.rdy, rise_a - r0, exp_rx);
    end
    cs_high();
    checks++;
    if (if_a.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ferr got %b exp 0", if_a.frame_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_miso();
    test_frame_err();
    test_random();
    test_overrun();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
